// File: rtl/rx_control_module.sv
`default_nettype none
// ============================================================================
// Module   : rx_control_module
// Brief    : Receive-side controller for an RS232 RX block. Parses fixed
//            4-byte frames (HEADER, CMD, DATA, CHK), executes LED commands
//            and reports valid/rejected frames with one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module rx_control_module #(
  parameter logic [18:0] T_TIMEOUT = 19'd499_999,
  parameter logic [7:0]  HEADER    = 8'hAA
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic [3:0] LED_Out,
  output logic [7:0] Cmd_Data,
  output logic       Frame_Valid_Sig,
  output logic       Frame_Err_Sig
);

  localparam logic [7:0] C_CMD_SET    = 8'h01;
  localparam logic [7:0] C_CMD_TOGGLE = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GET_CMD  = 2'd1,
    S_GET_DATA = 2'd2,
    S_GET_CHK  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [3:0]  led_q, led_d;
  logic        rx_en_q, rx_en_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [7:0]  sum_w;
  logic        timeout_w;

  // Expected checksum and timeout detection; a byte in the same cycle wins.
  always_comb begin
    sum_w     = cmd_q + data_q;
    timeout_w = (state_q != S_IDLE) && !RX_Done_Sig && (cnt_q == T_TIMEOUT);
  end

  // Next-state, frame execution and pulse generation.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_data_d = cmd_data_q;
    led_d      = led_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    rx_en_d    = ~RX_Done_Sig;

    if ((state_q == S_IDLE) || RX_Done_Sig || timeout_w) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 19'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (RX_Done_Sig && (RX_Data == HEADER)) begin
          state_d = S_GET_CMD;
        end
      end
      S_GET_CMD: begin
        if (RX_Done_Sig) begin
          cmd_d   = RX_Data;
          state_d = S_GET_DATA;
        end else if (timeout_w) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (RX_Done_Sig) begin
          data_d  = RX_Data;
          state_d = S_GET_CHK;
        end else if (timeout_w) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_GET_CHK: begin
        if (RX_Done_Sig) begin
          state_d = S_IDLE;
          if ((RX_Data == sum_w) && (cmd_q == C_CMD_SET)) begin
            led_d      = data_q[3:0];
            cmd_data_d = data_q;
            valid_d    = 1'b1;
          end else if ((RX_Data == sum_w) && (cmd_q == C_CMD_TOGGLE)) begin
            led_d      = led_q ^ data_q[3:0];
            cmd_data_d = data_q;
            valid_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_w) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      cmd_data_q <= '0;
      led_q      <= '0;
      rx_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      cmd_data_q <= cmd_data_d;
      led_q      <= led_d;
      rx_en_q    <= rx_en_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign RX_En_Sig       = rx_en_q;
  assign LED_Out         = led_q;
  assign Cmd_Data        = cmd_data_q;
  assign Frame_Valid_Sig = valid_q;
  assign Frame_Err_Sig   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_control_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_control_module
// Brief    : Self-checking bench for rx_control_module: frame-level reference
//            model, vector table, hand-written corner sequences, random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_control_module;

  localparam int         TT  = 40;
  localparam logic [7:0] HDR = 8'hAA;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RX_Done_Sig = 1'b0;
  logic [7:0] RX_Data = 8'h00;
  logic       RX_En_Sig;
  logic [3:0] LED_Out;
  logic [7:0] Cmd_Data;
  logic       Frame_Valid_Sig;
  logic       Frame_Err_Sig;

  int total = 0;
  int bad   = 0;

  rx_control_module #(
    .T_TIMEOUT(19'(TT)),
    .HEADER   (HDR)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .RX_Done_Sig    (RX_Done_Sig),
    .RX_Data        (RX_Data),
    .RX_En_Sig      (RX_En_Sig),
    .LED_Out        (LED_Out),
    .Cmd_Data       (Cmd_Data),
    .Frame_Valid_Sig(Frame_Valid_Sig),
    .Frame_Err_Sig  (Frame_Err_Sig)
  );

  always #5 CLK = ~CLK;

  // Frame-level reference model: bytes collected so far, idle gap, outputs.
  logic [7:0] fq[$];
  int         gap;
  logic [3:0] m_led;
  logic [7:0] m_cd;
  logic       m_v, m_e, m_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    gap   = 0;
    m_led = 4'h0;
    m_cd  = 8'h00;
    m_v   = 1'b0;
    m_e   = 1'b0;
    m_en  = 1'b0;
  endtask

  task automatic model_update(input logic d, input logic [7:0] b);
    int s;
    m_v  = 1'b0;
    m_e  = 1'b0;
    m_en = !d;
    if (d) begin
      gap = 0;
      if (fq.size() == 0) begin
        if (b == HDR) fq.push_back(b);
      end else begin
        fq.push_back(b);
        if (fq.size() == 4) begin
          s = (int'(fq[1]) + int'(fq[2])) % 256;
          if (s == int'(fq[3]) && fq[1] == 8'h01) begin
            m_led = fq[2][3:0];
            m_cd  = fq[2];
            m_v   = 1'b1;
          end else if (s == int'(fq[3]) && fq[1] == 8'h02) begin
            m_led = m_led ^ fq[2][3:0];
            m_cd  = fq[2];
            m_v   = 1'b1;
          end else begin
            m_e = 1'b1;
          end
          fq.delete();
        end
      end
    end else if (fq.size() != 0) begin
      gap++;
      if (gap == TT + 1) begin
        m_e = 1'b1;
        fq.delete();
        gap = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, advance, compare against the model.
  task automatic step(input logic d, input logic [7:0] b);
    RX_Done_Sig = d;
    RX_Data     = b;
    @(posedge CLK);
    #1;
    RX_Done_Sig = 1'b0;
    model_update(d, b);
    check("cycle", {17'd0, RX_En_Sig, LED_Out, Cmd_Data, Frame_Valid_Sig, Frame_Err_Sig},
          {17'd0, m_en, m_led, m_cd, m_v, m_e});
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    check("reset_vals", {17'd0, RX_En_Sig, LED_Out, Cmd_Data, Frame_Valid_Sig, Frame_Err_Sig}, 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic int gap_pick();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TT - 1;
    if (r == 1) return TT;
    if (r == 2) return TT + 1;
    return $urandom_range(0, 2);
  endfunction

  task automatic run_random(input int frames);
    int         nj, nb, sel;
    logic [7:0] jb, cmd, dat, chk;
    logic [7:0] fb[4];
    for (int f = 0; f < frames; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == HDR) jb = 8'h55;
        send_byte(jb);
        idle(gap_pick());
      end
      sel = $urandom_range(0, 9);
      cmd = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom_range(0, 255));
      dat = 8'($urandom_range(0, 255));
      chk = 8'((int'(cmd) + int'(dat)) % 256);
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'h01;
      fb[0] = HDR; fb[1] = cmd; fb[2] = dat; fb[3] = chk;
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 4;
      for (int k = 0; k < nb; k++) begin
        send_byte(fb[k]);
        idle(gap_pick());
      end
    end
    idle(TT + 2);
  endtask

  typedef struct {
    int          n;
    logic [47:0] seq;
    logic [3:0]  led;
    logic [7:0]  cd;
    logic        v;
    logic        e;
  } vec_t;

  function automatic vec_t mkv(input int n, input logic [47:0] seq, input logic [3:0] led,
                               input logic [7:0] cd, input logic v, input logic e);
    vec_t t;
    t.n = n; t.seq = seq; t.led = led; t.cd = cd; t.v = v; t.e = e;
    return t;
  endfunction

  vec_t tbl[8];

  initial begin
    logic [7:0] bb;
    tbl[0] = mkv(4, 48'hAA01_0506_0000, 4'h5, 8'h05, 1'b1, 1'b0);
    tbl[1] = mkv(4, 48'hAA02_0F11_0000, 4'hA, 8'h0F, 1'b1, 1'b0);
    tbl[2] = mkv(4, 48'hAA01_0507_0000, 4'hA, 8'h0F, 1'b0, 1'b1);
    tbl[3] = mkv(6, 48'h3155_AA03_0104, 4'hA, 8'h0F, 1'b0, 1'b1);
    tbl[4] = mkv(4, 48'hAA02_0305_0000, 4'h9, 8'h03, 1'b1, 1'b0);
    tbl[5] = mkv(4, 48'hAA01_FF00_0000, 4'hF, 8'hFF, 1'b1, 1'b0);
    tbl[6] = mkv(4, 48'hAAAA_01AB_0000, 4'hF, 8'hFF, 1'b0, 1'b1);
    tbl[7] = mkv(4, 48'hAA01_AAAB_0000, 4'hA, 8'hAA, 1'b1, 1'b0);

    model_reset();
    do_reset();
    idle(1);
    check("rx_en_after_reset", {31'd0, RX_En_Sig}, 32'd1);

    // Vector table: whole frames, outputs checked on the edge after CHK.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        bb = tbl[t].seq[47 - 8*i -: 8];
        send_byte(bb);
        if (i != tbl[t].n - 1) idle(1);
      end
      check($sformatf("table%0d", t), {18'd0, LED_Out, Cmd_Data, Frame_Valid_Sig, Frame_Err_Sig},
            {18'd0, tbl[t].led, tbl[t].cd, tbl[t].v, tbl[t].e});
      check($sformatf("table%0d_rxen", t), {31'd0, RX_En_Sig}, 32'd0);
      idle(1);
      check($sformatf("table%0d_pulse_end", t), {30'd0, Frame_Valid_Sig, Frame_Err_Sig}, 32'd0);
    end

    // Inter-byte timeout after AA,01.
    send_byte(8'hAA);
    send_byte(8'h01);
    begin
      int early;
      early = 0;
      for (int i = 0; i < TT; i++) begin
        step(1'b0, 8'h00);
        if (Frame_Err_Sig) early++;
      end
      check("timeout_not_early", early, 32'd0);
    end
    step(1'b0, 8'h00);
    check("timeout_err", {27'd0, LED_Out, Frame_Err_Sig}, {27'd0, 4'hA, 1'b1});
    idle(1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h04);
    check("after_timeout_frame", {27'd0, LED_Out, Frame_Valid_Sig}, {27'd0, 4'h3, 1'b1});

    // CHK byte arriving exactly when the counter hits the limit.
    idle(2);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05);
    idle(TT);
    send_byte(8'h06);
    check("chk_at_limit", {26'd0, LED_Out, Frame_Valid_Sig, Frame_Err_Sig}, {26'd0, 4'h5, 1'b1, 1'b0});
    idle(TT + 3);

    // Reset mid-frame discards the partial frame silently.
    send_byte(8'hAA); send_byte(8'h01);
    do_reset();
    idle(1);
    send_byte(8'hAA);
    check("rxen_low_after_byte", {31'd0, RX_En_Sig}, 32'd0);
    idle(1);
    check("rxen_rearmed", {31'd0, RX_En_Sig}, 32'd1);
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
    check("after_reset_frame", {19'd0, LED_Out, Cmd_Data, Frame_Valid_Sig},
          {19'd0, 4'h9, 8'h09, 1'b1});
    idle(2);

    run_random(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
